// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: ID/EX pipeline register plus operand delivery (ALU select decode, EX/MEM and MEM/WB forwarding) for MyALU.
// Latency: 1 cycle from ID capture to EX outputs; forwarding muxes are combinational on the stored source indices.
// Backpressure: stall holds the slot but keeps refreshing stored rs/rt data with the forwarded values; flush and rst load a bubble.
// Ports:
//   clk, rst (sync, active-high), stall, flush          - control
//   id_*                                                - decoded instruction from ID
//   exm_reg_write/exm_rd_addr/exm_result               - EX/MEM producer
//   wb_reg_write/wb_rd_addr/wb_data                    - MEM/WB producer
//   ex_valid, operand1, operand2, alu_select,
//   ex_store_data, ex_dest_addr, ex_reg_write,
//   ex_illegal                                          - EX-side outputs
module id_ex_operand_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int FORWARD_EN = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic [DATA_W-1:0]     id_rs_data,
  input  logic [DATA_W-1:0]     id_rt_data,
  input  logic [DATA_W-1:0]     id_imm,
  input  logic [REG_ADDR_W-1:0] id_rs_addr,
  input  logic [REG_ADDR_W-1:0] id_rt_addr,
  input  logic [REG_ADDR_W-1:0] id_rd_addr,
  input  logic [1:0]            id_alu_op,
  input  logic [5:0]            id_funct,
  input  logic                  id_alu_src,
  input  logic                  id_reg_dst,
  input  logic                  id_reg_write,
  input  logic                  exm_reg_write,
  input  logic [REG_ADDR_W-1:0] exm_rd_addr,
  input  logic [DATA_W-1:0]     exm_result,
  input  logic                  wb_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_rd_addr,
  input  logic [DATA_W-1:0]     wb_data,
  output logic                  ex_valid,
  output logic [DATA_W-1:0]     operand1,
  output logic [DATA_W-1:0]     operand2,
  output logic [3:0]            alu_select,
  output logic [DATA_W-1:0]     ex_store_data,
  output logic [REG_ADDR_W-1:0] ex_dest_addr,
  output logic                  ex_reg_write,
  output logic                  ex_illegal
);

  // Stored ID/EX fields
  logic                  valid_q;
  logic [DATA_W-1:0]     rs_data_q;
  logic [DATA_W-1:0]     rt_data_q;
  logic [DATA_W-1:0]     imm_q;
  logic [REG_ADDR_W-1:0] rs_addr_q;
  logic [REG_ADDR_W-1:0] rt_addr_q;
  logic [REG_ADDR_W-1:0] dest_q;
  logic [3:0]            sel_q;
  logic                  illegal_q;
  logic                  alu_src_q;
  logic                  reg_write_q;

  // Decode of the incoming instruction into the MyALU select code
  logic [3:0] id_sel;
  logic       id_illegal;

  always_comb begin
    id_sel     = 4'b1111;
    id_illegal = 1'b1;
    case (id_alu_op)
      2'b00: begin id_sel = 4'b0010; id_illegal = 1'b0; end
      2'b01: begin id_sel = 4'b0110; id_illegal = 1'b0; end
      2'b10: begin
        case (id_funct)
          6'b100000: begin id_sel = 4'b0010; id_illegal = 1'b0; end
          6'b100010: begin id_sel = 4'b0110; id_illegal = 1'b0; end
          6'b100100: begin id_sel = 4'b0000; id_illegal = 1'b0; end
          6'b100101: begin id_sel = 4'b0001; id_illegal = 1'b0; end
          6'b101010: begin id_sel = 4'b0111; id_illegal = 1'b0; end
          default:   begin id_sel = 4'b1111; id_illegal = 1'b1; end
        endcase
      end
      default: begin id_sel = 4'b1111; id_illegal = 1'b1; end
    endcase
  end

  // Forwarding: the younger EX/MEM producer wins over MEM/WB; r0 is hard-wired zero
  // so it is never a forwarding target.
  logic fwd_en;
  logic rs_exm_hit, rs_wb_hit, rt_exm_hit, rt_wb_hit;
  logic [DATA_W-1:0] fwd_rs, fwd_rt;

  assign fwd_en     = (FORWARD_EN != 0);
  assign rs_exm_hit = fwd_en && exm_reg_write && (exm_rd_addr == rs_addr_q) && (rs_addr_q != '0);
  assign rs_wb_hit  = fwd_en && wb_reg_write  && (wb_rd_addr  == rs_addr_q) && (rs_addr_q != '0);
  assign rt_exm_hit = fwd_en && exm_reg_write && (exm_rd_addr == rt_addr_q) && (rt_addr_q != '0);
  assign rt_wb_hit  = fwd_en && wb_reg_write  && (wb_rd_addr  == rt_addr_q) && (rt_addr_q != '0);

  assign fwd_rs = rs_exm_hit ? exm_result : (rs_wb_hit ? wb_data : rs_data_q);
  assign fwd_rt = rt_exm_hit ? exm_result : (rt_wb_hit ? wb_data : rt_data_q);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid_q     <= 1'b0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_q       <= '0;
      rs_addr_q   <= '0;
      rt_addr_q   <= '0;
      dest_q      <= '0;
      sel_q       <= '0;
      illegal_q   <= 1'b0;
      alu_src_q   <= 1'b0;
      reg_write_q <= 1'b0;
    end else if (stall) begin
      // A producer may retire from WB while we wait; latch its value now so the
      // operand is still correct once it is no longer visible on the bypass.
      rs_data_q <= fwd_rs;
      rt_data_q <= fwd_rt;
    end else begin
      valid_q     <= id_valid;
      rs_data_q   <= id_rs_data;
      rt_data_q   <= id_rt_data;
      imm_q       <= id_imm;
      rs_addr_q   <= id_rs_addr;
      rt_addr_q   <= id_rt_addr;
      dest_q      <= id_reg_dst ? id_rd_addr : id_rt_addr;
      sel_q       <= id_sel;
      illegal_q   <= id_illegal;
      alu_src_q   <= id_alu_src;
      reg_write_q <= id_reg_write;
    end
  end

  // Bubbles present all-zero operands and controls to the ALU and later stages.
  assign ex_valid      = valid_q;
  assign operand1      = valid_q ? fwd_rs : '0;
  assign operand2      = valid_q ? (alu_src_q ? imm_q : fwd_rt) : '0;
  assign ex_store_data = valid_q ? fwd_rt : '0;
  assign alu_select    = valid_q ? sel_q : 4'b0000;
  assign ex_illegal    = valid_q & illegal_q;
  assign ex_reg_write  = valid_q & reg_write_q;
  assign ex_dest_addr  = dest_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: reset, decode, forwarding priority,
// stall refresh, flush-over-stall, reset during stall, illegal ops and bubble gating.
module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush, id_valid;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_rs_addr, id_rt_addr, id_rd_addr;
  logic [1:0]  id_alu_op;
  logic [5:0]  id_funct;
  logic        id_alu_src, id_reg_dst, id_reg_write;
  logic        exm_reg_write;
  logic [4:0]  exm_rd_addr;
  logic [31:0] exm_result;
  logic        wb_reg_write;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_data;
  logic        ex_valid;
  logic [31:0] operand1, operand2, ex_store_data;
  logic [3:0]  alu_select;
  logic [4:0]  ex_dest_addr;
  logic        ex_reg_write, ex_illegal;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  id_ex_operand_stage #(.DATA_W(32), .REG_ADDR_W(5), .FORWARD_EN(1)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr),
    .id_alu_op(id_alu_op), .id_funct(id_funct), .id_alu_src(id_alu_src),
    .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write),
    .exm_reg_write(exm_reg_write), .exm_rd_addr(exm_rd_addr), .exm_result(exm_result),
    .wb_reg_write(wb_reg_write), .wb_rd_addr(wb_rd_addr), .wb_data(wb_data),
    .ex_valid(ex_valid), .operand1(operand1), .operand2(operand2),
    .alu_select(alu_select), .ex_store_data(ex_store_data), .ex_dest_addr(ex_dest_addr),
    .ex_reg_write(ex_reg_write), .ex_illegal(ex_illegal)
  );

  // Advance one clock; outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(input logic v, input logic [4:0] rs_a, input logic [31:0] rs_d,
                          input logic [4:0] rt_a, input logic [31:0] rt_d, input logic [4:0] rd_a,
                          input logic [31:0] imm, input logic [1:0] op, input logic [5:0] fn,
                          input logic src, input logic dst, input logic rw);
    id_valid = v;  id_rs_addr = rs_a; id_rs_data = rs_d; id_rt_addr = rt_a; id_rt_data = rt_d;
    id_rd_addr = rd_a; id_imm = imm; id_alu_op = op; id_funct = fn;
    id_alu_src = src; id_reg_dst = dst; id_reg_write = rw;
  endtask

  task automatic clear_fwd();
    exm_reg_write = 0; exm_rd_addr = 0; exm_result = 0;
    wb_reg_write = 0;  wb_rd_addr = 0;  wb_data = 0;
  endtask

  task automatic test_reset();
    rst = 1; stall = 0; flush = 0; clear_fwd();
    drive_id(1, 5'd5, 32'h3, 5'd6, 32'h9, 5'd7, 32'h55, 2'b10, 6'h2A, 0, 1, 1);
    tick(); tick();
    n_checks++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ex_valid got %h want 0", ex_valid); end
    n_checks++; if (operand1 !== 32'h0) begin n_fail++; $display("FAIL reset_operand1 got %h want 0", operand1); end
    n_checks++; if (operand2 !== 32'h0) begin n_fail++; $display("FAIL reset_operand2 got %h want 0", operand2); end
    n_checks++; if (alu_select !== 4'h0) begin n_fail++; $display("FAIL reset_alu_select got %h want 0", alu_select); end
    n_checks++; if (ex_store_data !== 32'h0) begin n_fail++; $display("FAIL reset_store got %h want 0", ex_store_data); end
    n_checks++; if (ex_dest_addr !== 5'h0) begin n_fail++; $display("FAIL reset_dest got %h want 0", ex_dest_addr); end
    n_checks++; if ({ex_reg_write, ex_illegal} !== 2'b00) begin n_fail++; $display("FAIL reset_rw_ill got %b want 00", {ex_reg_write, ex_illegal}); end
    rst = 0;
  endtask

  task automatic test_decode();
    logic [1:0] ops [6] = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10};
    logic [5:0] fns [6] = '{6'h00, 6'h00, 6'h20, 6'h22, 6'h24, 6'h25};
    logic [3:0] sels[6] = '{4'b0010, 4'b0110, 4'b0010, 4'b0110, 4'b0000, 4'b0001};
    // slt, rs=5 (3), rt=6 (9), dest rd=7
    drive_id(1, 5'd5, 32'h3, 5'd6, 32'h9, 5'd7, 32'h1234, 2'b10, 6'h2A, 0, 1, 1);
    tick();
    n_checks++; if (alu_select !== 4'b0111) begin n_fail++; $display("FAIL slt_select got %b want 0111", alu_select); end
    n_checks++; if (operand1 !== 32'h3) begin n_fail++; $display("FAIL slt_operand1 got %h want 3", operand1); end
    n_checks++; if (operand2 !== 32'h9) begin n_fail++; $display("FAIL slt_operand2 got %h want 9", operand2); end
    n_checks++; if (ex_dest_addr !== 5'd7) begin n_fail++; $display("FAIL slt_dest got %0d want 7", ex_dest_addr); end
    n_checks++; if ({ex_valid, ex_reg_write, ex_illegal} !== 3'b110) begin n_fail++; $display("FAIL slt_flags got %b want 110", {ex_valid, ex_reg_write, ex_illegal}); end
    n_checks++; if (ex_store_data !== 32'h9) begin n_fail++; $display("FAIL slt_store got %h want 9", ex_store_data); end
    // back-to-back decode table, new instruction each cycle
    for (int i = 0; i < 6; i++) begin
      drive_id(1, 5'd1, 32'h100 + i, 5'd2, 32'h200, 5'd3, 32'h0, ops[i], fns[i], 0, 1, 1);
      tick();
      n_checks++; if (alu_select !== sels[i] || ex_illegal !== 1'b0) begin n_fail++; $display("FAIL decode_%0d got sel %b ill %b want %b 0", i, alu_select, ex_illegal, sels[i]); end
      n_checks++; if (operand1 !== 32'h100 + i) begin n_fail++; $display("FAIL b2b_op1_%0d got %h want %h", i, operand1, 32'h100 + i); end
    end
    // immediate operand, rt destination
    drive_id(1, 5'd2, 32'hA, 5'd3, 32'hB, 5'd9, 32'hFFFF_FFF0, 2'b00, 6'h00, 1, 0, 1);
    tick();
    n_checks++; if (operand2 !== 32'hFFFF_FFF0) begin n_fail++; $display("FAIL imm_operand2 got %h want fffffff0", operand2); end
    n_checks++; if (ex_store_data !== 32'hB) begin n_fail++; $display("FAIL imm_store got %h want b", ex_store_data); end
    n_checks++; if (ex_dest_addr !== 5'd3) begin n_fail++; $display("FAIL rt_dest got %0d want 3", ex_dest_addr); end
  endtask

  task automatic test_forward();
    drive_id(1, 5'd8, 32'h5, 5'd9, 32'h6, 5'd10, 32'h0, 2'b10, 6'h20, 0, 1, 1);
    tick();
    exm_reg_write = 1; exm_rd_addr = 8; exm_result = 32'h11;
    wb_reg_write = 1;  wb_rd_addr = 8;  wb_data = 32'h22;
    #1;
    n_checks++; if (operand1 !== 32'h11) begin n_fail++; $display("FAIL fwd_exm_priority got %h want 11", operand1); end
    n_checks++; if (operand2 !== 32'h6) begin n_fail++; $display("FAIL fwd_rt_untouched got %h want 6", operand2); end
    exm_reg_write = 0;
    #1;
    n_checks++; if (operand1 !== 32'h22) begin n_fail++; $display("FAIL fwd_wb got %h want 22", operand1); end
    wb_reg_write = 0;
    #1;
    n_checks++; if (operand1 !== 32'h5) begin n_fail++; $display("FAIL fwd_none got %h want 5", operand1); end
    exm_reg_write = 1; exm_rd_addr = 9; exm_result = 32'h33;
    #1;
    n_checks++; if (operand2 !== 32'h33 || ex_store_data !== 32'h33) begin n_fail++; $display("FAIL fwd_rt got op2 %h store %h want 33", operand2, ex_store_data); end
    clear_fwd();
    // r0 is never forwarded
    drive_id(1, 5'd0, 32'h5, 5'd0, 32'h6, 5'd10, 32'h0, 2'b10, 6'h20, 0, 1, 1);
    tick();
    exm_reg_write = 1; exm_rd_addr = 0; exm_result = 32'h11;
    wb_reg_write = 1;  wb_rd_addr = 0;  wb_data = 32'h22;
    #1;
    n_checks++; if (operand1 !== 32'h5) begin n_fail++; $display("FAIL fwd_r0_exm got %h want 5", operand1); end
    n_checks++; if (operand2 !== 32'h6) begin n_fail++; $display("FAIL fwd_r0_rt got %h want 6", operand2); end
    exm_reg_write = 0;
    #1;
    n_checks++; if (operand1 !== 32'h5) begin n_fail++; $display("FAIL fwd_r0_wb got %h want 5", operand1); end
    clear_fwd();
  endtask

  task automatic test_stall_refresh();
    drive_id(1, 5'd1, 32'h1, 5'd4, 32'h0, 5'd12, 32'h0, 2'b10, 6'h20, 0, 1, 1);
    tick();
    stall = 1;
    wb_reg_write = 1; wb_rd_addr = 4; wb_data = 32'hAB;
    drive_id(1, 5'd7, 32'h77, 5'd7, 32'h77, 5'd15, 32'h77, 2'b01, 6'h00, 1, 1, 0);
    tick();
    wb_reg_write = 0; wb_data = 0;
    #1;
    n_checks++; if (operand2 !== 32'hAB) begin n_fail++; $display("FAIL stall_refresh got %h want ab", operand2); end
    n_checks++; if (ex_dest_addr !== 5'd12 || operand1 !== 32'h1) begin n_fail++; $display("FAIL stall_hold got dest %0d op1 %h want 12 1", ex_dest_addr, operand1); end
    tick();
    n_checks++; if (operand2 !== 32'hAB) begin n_fail++; $display("FAIL stall_second got %h want ab", operand2); end
    stall = 0;
    #1;
    n_checks++; if (operand2 !== 32'hAB || alu_select !== 4'b0010) begin n_fail++; $display("FAIL stall_release got op2 %h sel %b want ab 0010", operand2, alu_select); end
  endtask

  task automatic test_flush_stall();
    drive_id(1, 5'd1, 32'h1, 5'd2, 32'h2, 5'd3, 32'h0, 2'b10, 6'h20, 0, 1, 1);
    tick();
    n_checks++; if (ex_valid !== 1'b1 || ex_reg_write !== 1'b1) begin n_fail++; $display("FAIL pre_flush got v %b rw %b want 1 1", ex_valid, ex_reg_write); end
    // sw r3 -> 4(r2)
    drive_id(1, 5'd2, 32'h10, 5'd3, 32'h20, 5'd0, 32'h4, 2'b00, 6'h00, 1, 0, 0);
    flush = 1; stall = 1;
    tick();
    n_checks++; if ({ex_valid, ex_reg_write} !== 2'b00) begin n_fail++; $display("FAIL flush_flags got %b want 00", {ex_valid, ex_reg_write}); end
    n_checks++; if (operand1 !== 0 || operand2 !== 0 || ex_store_data !== 0) begin n_fail++; $display("FAIL flush_operands got %h %h %h want 0", operand1, operand2, ex_store_data); end
    n_checks++; if (alu_select !== 4'h0 || ex_dest_addr !== 5'h0) begin n_fail++; $display("FAIL flush_sel_dest got %b %0d want 0 0", alu_select, ex_dest_addr); end
    flush = 0; stall = 0;
    tick();
    n_checks++; if (operand1 !== 32'h10 || operand2 !== 32'h4 || ex_store_data !== 32'h20) begin n_fail++; $display("FAIL sw_load got %h %h %h want 10 4 20", operand1, operand2, ex_store_data); end
    n_checks++; if ({ex_valid, ex_reg_write} !== 2'b10) begin n_fail++; $display("FAIL sw_flags got %b want 10", {ex_valid, ex_reg_write}); end
    // reset while stalled clears the slot
    stall = 1; rst = 1;
    tick();
    n_checks++; if (ex_valid !== 1'b0 || operand1 !== 32'h0) begin n_fail++; $display("FAIL rst_stall got v %b op1 %h want 0 0", ex_valid, operand1); end
    stall = 0; rst = 0;
  endtask

  task automatic test_illegal();
    drive_id(1, 5'd5, 32'h3, 5'd6, 32'h9, 5'd7, 32'h0, 2'b10, 6'h00, 0, 1, 1);
    tick();
    n_checks++; if (alu_select !== 4'b1111 || ex_illegal !== 1'b1) begin n_fail++; $display("FAIL illegal_funct got %b %b want 1111 1", alu_select, ex_illegal); end
    drive_id(1, 5'd5, 32'h3, 5'd6, 32'h9, 5'd7, 32'h0, 2'b11, 6'h20, 0, 1, 1);
    tick();
    n_checks++; if (alu_select !== 4'b1111 || ex_illegal !== 1'b1) begin n_fail++; $display("FAIL illegal_op11 got %b %b want 1111 1", alu_select, ex_illegal); end
    // an invalid slot with illegal fields is gated to zero
    drive_id(0, 5'd5, 32'h3, 5'd6, 32'h9, 5'd7, 32'h0, 2'b11, 6'h00, 0, 1, 1);
    tick();
    n_checks++; if ({ex_valid, ex_illegal, ex_reg_write} !== 3'b000 || alu_select !== 4'h0) begin n_fail++; $display("FAIL bubble_gate got %b sel %b want 000 0000", {ex_valid, ex_illegal, ex_reg_write}, alu_select); end
    n_checks++; if (operand1 !== 0 || operand2 !== 0 || ex_store_data !== 0) begin n_fail++; $display("FAIL bubble_operands got %h %h %h want 0", operand1, operand2, ex_store_data); end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_forward();
    test_stall_refresh();
    test_flush_stall();
    test_illegal();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
